// File: rtl/serial_stream_tx.sv
// serial_stream_tx
// Serializes one WIDTH-bit word, MSB first, into the 2-bit symbol stream
// expected by the stream parser: one data bit per tx_en cycle, with
// end_of_sequence flagged on the word's last bit. After each word the
// block waits GAP_CYCLES idle cycles before it accepts the next load.
//
// Ports:
//   clk             rising-edge clock
//   rst_n           asynchronous active-low reset
//   load_valid      load_data is valid
//   load_data       word to send (bit WIDTH-1 goes first)
//   load_ready      block can accept a word (state is IDLE)
//   tx_en           downstream accepts a symbol this cycle
//   abort           synchronous cancel of the word in flight
//   tx_info         registered symbol: 00 idle/hold, 01 bit=1, 10 bit=0
//   end_of_sequence registered, high with the word's last bit
//   busy            state is not IDLE
module serial_stream_tx #(
  parameter int unsigned WIDTH      = 128,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  input  logic             tx_en,
  input  logic             abort,
  output logic [1:0]       tx_info,
  output logic             end_of_sequence,
  output logic             busy
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic [GW-1:0]    gap_q,   gap_d;
  logic [1:0]       info_q,  info_d;
  logic             eos_q,   eos_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
      info_q  <= 2'b00;
      eos_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      info_q  <= info_d;
      eos_q   <= eos_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    info_d  = 2'b00;
    eos_d   = 1'b0;

    if (abort) begin
      // Abort outranks everything, including a pending load and the last bit.
      state_d = IDLE;
      cnt_d   = '0;
      gap_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (load_valid) begin
            shreg_d = load_data;
            cnt_d   = '0;
            state_d = SEND;
          end
        end
        SEND: begin
          if (tx_en) begin
            info_d  = shreg_q[WIDTH-1] ? 2'b01 : 2'b10;
            shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
            if (cnt_q == LAST_BIT) begin
              // Clear rather than increment so the counter never wraps.
              cnt_d   = '0;
              gap_d   = '0;
              eos_d   = 1'b1;
              state_d = (GAP_CYCLES > 0) ? GAP : IDLE;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        GAP: begin
          if (gap_q == GAP_LAST) begin
            gap_d   = '0;
            state_d = IDLE;
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign tx_info         = info_q;
  assign end_of_sequence = eos_q;
  assign busy            = (state_q != IDLE);
  assign load_ready      = (state_q == IDLE);

endmodule

// File: tb/tb_serial_stream_tx.sv
module tb_serial_stream_tx;

  localparam int unsigned W = 128;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         load_valid;
  logic [W-1:0] load_data;
  logic         load_ready;
  logic         tx_en;
  logic         abort;
  logic [1:0]   tx_info;
  logic         end_of_sequence;
  logic         busy;

  always #5 clk = ~clk;

  serial_stream_tx #(.WIDTH(W), .GAP_CYCLES(2)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .load_valid      (load_valid),
    .load_data       (load_data),
    .load_ready      (load_ready),
    .tx_en           (tx_en),
    .abort           (abort),
    .tx_info         (tx_info),
    .end_of_sequence (end_of_sequence),
    .busy            (busy)
  );

  typedef struct packed {
    logic b;
    logic last;
  } sym_t;

  sym_t         exp_q[$];
  logic [W-1:0] word_q[$];
  logic [W-1:0] parser_reg = '0;
  int           n_chk  = 0;
  int           n_fail = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: pops one expected bit per presented symbol and models the parser register.
  always @(negedge clk) begin
    sym_t s;
    if (rst_n) begin
      if (tx_info == 2'b00) begin
        check("eos_on_idle_symbol", end_of_sequence, 0);
      end else if (exp_q.size() == 0) begin
        check("unexpected_symbol", tx_info, 0);
      end else begin
        s = exp_q.pop_front();
        check("symbol", tx_info, s.b ? 2'b01 : 2'b10);
        check("eos_flag", end_of_sequence, s.last);
        parser_reg = {parser_reg[W-2:0], (tx_info == 2'b01)};
        if (end_of_sequence) begin
          if (word_q.size() == 0) check("parser_no_word", 1, 0);
          else check("parser_word", parser_reg, word_q.pop_front());
        end
      end
    end
  end

  task automatic push_word(input logic [W-1:0] w);
    for (int i = W - 1; i >= 0; i--) exp_q.push_back({w[i], (i == 0)});
    word_q.push_back(w);
  endtask

  task automatic do_load(input logic [W-1:0] w);
    int t = 0;
    while (!load_ready && t < 1000) begin
      @(posedge clk); #1; t++;
    end
    check("load_ready_timeout", (t < 1000), 1);
    push_word(w);
    load_valid = 1'b1;
    load_data  = w;
    @(posedge clk); #1;
    load_valid = 1'b0;
    load_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
    check("busy_after_load", busy, 1);
    check("ready_after_load", load_ready, 0);
  endtask

  task automatic wait_done();
    int t = 0;
    while ((busy || exp_q.size() != 0) && t < 2000) begin
      @(posedge clk); #1; t++;
    end
    check("done_timeout", (t < 2000), 1);
    check("word_completed", word_q.size(), 0);
  endtask

  task automatic wait_symbols(input int n);
    int seen = 0;
    int t = 0;
    while (seen < n && t < 1000) begin
      @(posedge clk); #1; t++;
      if (tx_info != 2'b00) seen++;
    end
    check("symbol_count_timeout", seen, n);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int first;
    int last;
    int ce;
    int c2;
    int c;

    rst_n      = 1'b1;
    load_valid = 1'b0;
    load_data  = '0;
    tx_en      = 1'b1;
    abort      = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("reset_tx_info", tx_info, 0);
    check("reset_eos", end_of_sequence, 0);
    check("reset_load_ready", load_ready, 1);
    check("reset_busy", busy, 0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // MSB/LSB set, tx_en held high: first symbol one edge after the load.
    do_load(128'h8000_0000_0000_0000_0000_0000_0000_0001);
    @(posedge clk); #1;
    check("first_symbol_latency", tx_info, 2'b01);
    wait_done();

    // A5 pattern with tx_en toggling: every stalled cycle shows 00.
    do_load({16{8'hA5}});
    first = -1;
    last  = -1;
    for (int i = 0; i < 400; i++) begin
      tx_en = (i % 2 == 0);
      @(posedge clk); #1;
      if (!tx_en) check("stall_symbol_idle", tx_info, 0);
      if (tx_info != 2'b00 && first < 0) first = i;
      if (end_of_sequence) begin
        last = i;
        break;
      end
    end
    tx_en = 1'b1;
    check("stalled_word_span", last - first + 1, 255);
    wait_done();

    // Abort after 64 symbols: no eos, immediate return to IDLE.
    do_load('1);
    wait_symbols(64);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_tx_info", tx_info, 0);
    check("abort_eos", end_of_sequence, 0);
    check("abort_busy", busy, 0);
    check("abort_load_ready", load_ready, 1);
    exp_q.delete();
    void'(word_q.pop_back());

    // abort together with load_valid in IDLE blocks the load.
    load_valid = 1'b1;
    load_data  = '1;
    abort      = 1'b1;
    @(posedge clk); #1;
    load_valid = 1'b0;
    abort      = 1'b0;
    check("abort_blocks_load", busy, 0);

    do_load('0);
    wait_done();

    // Back-to-back offers with load_valid held: 3 idle symbols between words.
    push_word({16{8'h0F}});
    load_valid = 1'b1;
    load_data  = {16{8'h0F}};
    @(posedge clk); #1;
    load_data  = {16{8'h3C}};
    push_word({16{8'h3C}});
    c  = 0;
    ce = -1;
    c2 = -1;
    while (c2 < 0 && c < 600) begin
      @(posedge clk); #1; c++;
      if (ce < 0) begin
        if (end_of_sequence) ce = c;
      end else if (tx_info != 2'b00) begin
        c2 = c;
      end
    end
    load_valid = 1'b0;
    check("b2b_eos_to_next_symbol", c2 - ce, 4);
    wait_done();

    // Reset mid-word after 40 bits, then a fresh word from its MSB.
    do_load({4{32'hDEAD_BEEF}});
    wait_symbols(40);
    #1 rst_n = 1'b0;
    #1;
    check("async_reset_tx_info", tx_info, 0);
    check("async_reset_eos", end_of_sequence, 0);
    check("async_reset_busy", busy, 0);
    check("async_reset_load_ready", load_ready, 1);
    exp_q.delete();
    word_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_load(128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF);
    @(posedge clk); #1;
    check("post_reset_msb", tx_info, 2'b10);
    wait_done();

    repeat (4) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
